// File: rtl/ethernet_tx_pkg.sv
// Shared definitions for the Ethernet/UDP transmit path: serializer state
// encoding and the default frame-geometry constants.
package ethernet_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_HEAD    = 3'd1,
      ST_PAYLOAD = 3'd2,
      ST_PAD     = 3'd3,
      ST_GAP     = 3'd4
   } tx_state_t;

   localparam int DEF_HEAD_BYTES      = 42;
   localparam int DEF_MIN_FRAME_BYTES = 60;
   localparam int DEF_IFG_CYCLES      = 12;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/ethernet_ifg_counter.sv
// Inter-frame gap down-counter: loaded on the last byte of a frame, o_done
// rises once the requested number of idle cycles has elapsed.
module ethernet_ifg_counter #(
   parameter int IFG_CYCLES = 12
)(
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_load,
   output logic o_done
);
   localparam int            W        = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
   localparam logic [W-1:0]  LOAD_VAL = (IFG_CYCLES > 1) ? W'(IFG_CYCLES - 1) : '0;

   logic [W-1:0] r_cnt;

   // Count down to zero; the serializer leaves GAP on the edge that sees zero.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= LOAD_VAL;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ethernet_udp_frame_serializer.sv
// Byte-serial transmitter for a header + payload frame with minimum-length
// zero padding, downstream back-pressure and a forced inter-frame gap.
module ethernet_udp_frame_serializer
   import ethernet_tx_pkg::*;
#(
   parameter int HEAD_BYTES        = DEF_HEAD_BYTES,
   parameter int MAX_PAYLOAD_BYTES = 63,
   parameter int SIZE_W            = 16,
   parameter int MIN_FRAME_BYTES   = DEF_MIN_FRAME_BYTES,
   parameter int IFG_CYCLES        = DEF_IFG_CYCLES
)(
   input  logic                           i_clk,
   input  logic                           i_reset_n,
   input  logic [HEAD_BYTES*8-1:0]        i_head,
   input  logic [MAX_PAYLOAD_BYTES*8-1:0] i_payload,
   input  logic [SIZE_W-1:0]              i_payload_size,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic                           i_tx_ready,
   output logic [7:0]                     o_word,
   output logic                           o_valid,
   output logic                           o_sof,
   output logic                           o_eof,
   output logic                           o_size_err,
   output logic                           o_busy
);
   localparam int HB    = HEAD_BYTES * 8;
   localparam int PB    = MAX_PAYLOAD_BYTES * 8;
   localparam int CNT_W = $clog2(HEAD_BYTES + max_int(MAX_PAYLOAD_BYTES, MIN_FRAME_BYTES) + 1);

   localparam logic [CNT_W-1:0]  HEAD_CNT = CNT_W'(HEAD_BYTES);
   localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_FRAME_BYTES);
   localparam logic [CNT_W-1:0]  MAXP_CNT = CNT_W'(MAX_PAYLOAD_BYTES);
   localparam logic [SIZE_W-1:0] MAXP_SZ  = SIZE_W'(MAX_PAYLOAD_BYTES);

   tx_state_t        r_state;
   logic [HB-1:0]    r_head;
   logic [PB-1:0]    r_payload;
   logic [CNT_W-1:0] r_size;
   logic [CNT_W-1:0] r_len;
   logic [CNT_W-1:0] r_idx;
   logic [7:0]       r_word;
   logic             r_valid;
   logic             r_sof;
   logic             r_eof;
   logic             r_size_err;
   logic             r_busy;
   logic             r_ready;

   logic             w_size_over;
   logic [CNT_W-1:0] w_size_clamp;
   logic [CNT_W-1:0] w_hs;
   logic [CNT_W-1:0] w_len;
   logic [CNT_W-1:0] w_next_idx;
   logic [CNT_W-1:0] w_data_end;
   logic             w_adv;
   logic             w_last;
   logic             w_ifg_load;
   logic             w_ifg_done;

   // Frame length is fixed at acceptance: header + clamped payload, raised to the minimum.
   always_comb begin
      w_size_over  = (i_payload_size > MAXP_SZ);
      w_size_clamp = w_size_over ? MAXP_CNT : CNT_W'(i_payload_size);
      w_hs         = HEAD_CNT + w_size_clamp;
      w_len        = (w_hs < MIN_CNT) ? MIN_CNT : w_hs;
      w_adv        = r_valid & i_tx_ready;
      w_next_idx   = r_idx + CNT_W'(1);
      w_last       = (r_idx == (r_len - CNT_W'(1)));
      w_data_end   = HEAD_CNT + r_size;
      w_ifg_load   = w_adv & w_last;
   end

   ethernet_ifg_counter #(
      .IFG_CYCLES (IFG_CYCLES)
   ) u_ifg (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_load    (w_ifg_load),
      .o_done    (w_ifg_done)
   );

   // Frame sequencer; header and payload are shifted so the next byte is always the MS byte.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= ST_IDLE;
         r_head     <= '0;
         r_payload  <= '0;
         r_size     <= '0;
         r_len      <= '0;
         r_idx      <= '0;
         r_word     <= 8'h00;
         r_valid    <= 1'b0;
         r_sof      <= 1'b0;
         r_eof      <= 1'b0;
         r_size_err <= 1'b0;
         r_busy     <= 1'b0;
         r_ready    <= 1'b0;
      end else begin
         r_size_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_valid && r_ready) begin
                  r_head     <= i_head << 4'd8;
                  r_payload  <= i_payload;
                  r_size     <= w_size_clamp;
                  r_len      <= w_len;
                  r_idx      <= '0;
                  r_size_err <= w_size_over;
                  r_word     <= i_head[HB-1 -: 8];
                  r_valid    <= 1'b1;
                  r_sof      <= 1'b1;
                  r_eof      <= (w_len == CNT_W'(1));
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= ST_HEAD;
               end else begin
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            ST_HEAD, ST_PAYLOAD, ST_PAD: begin
               if (w_adv) begin
                  r_sof <= 1'b0;
                  if (w_last) begin
                     r_word  <= 8'h00;
                     r_valid <= 1'b0;
                     r_eof   <= 1'b0;
                     r_idx   <= '0;
                     if (IFG_CYCLES > 0) begin
                        r_state <= ST_GAP;
                     end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                     end
                  end else begin
                     r_idx <= w_next_idx;
                     r_eof <= (w_next_idx == (r_len - CNT_W'(1)));
                     if (w_next_idx < HEAD_CNT) begin
                        r_word  <= r_head[HB-1 -: 8];
                        r_head  <= r_head << 4'd8;
                        r_state <= ST_HEAD;
                     end else if (w_next_idx < w_data_end) begin
                        r_word    <= r_payload[PB-1 -: 8];
                        r_payload <= r_payload << 4'd8;
                        r_state   <= ST_PAYLOAD;
                     end else begin
                        r_word  <= 8'h00;
                        r_state <= ST_PAD;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (w_ifg_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_word  <= 8'h00;
               r_valid <= 1'b0;
               r_sof   <= 1'b0;
               r_eof   <= 1'b0;
               r_busy  <= 1'b0;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   assign o_ready    = r_ready;
   assign o_word     = r_word;
   assign o_valid    = r_valid;
   assign o_sof      = r_sof;
   assign o_eof      = r_eof;
   assign o_size_err = r_size_err;
   assign o_busy     = r_busy;

endmodule

// File: doc/ethernet_udp_frame_serializer.md
ETHERNET_UDP_FRAME_SERIALIZER -- requirements
Module: ethernet_udp_frame_serializer

Interface
REQ-001 SHALL have parameter HEAD_BYTES, default 42, header length in bytes (1..64).
REQ-002 SHALL have parameter MAX_PAYLOAD_BYTES, default 63, payload buffer capacity in bytes (1..1500).
REQ-003 SHALL have parameter SIZE_W, default 16, width of the payload size field.
REQ-004 SHALL have parameter MIN_FRAME_BYTES, default 60, minimum header+payload length; shorter frames are zero-padded (0 disables padding).
REQ-005 SHALL have parameter IFG_CYCLES, default 12, idle cycles forced after each frame (0 allowed).
REQ-006 SHALL have port i_clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port i_head  input  HEAD_BYTES*8  header; MS byte is sent first.
REQ-009 SHALL have port i_payload  input  MAX_PAYLOAD_BYTES*8  payload; MS byte is sent first.
REQ-010 SHALL have port i_payload_size  input  SIZE_W  payload byte count.
REQ-011 SHALL have port i_valid  input  1  frame request; accepted when i_valid and o_ready are both 1 at a clock edge.
REQ-012 SHALL have port o_ready  output  1  block can accept a frame.
REQ-013 SHALL have port i_tx_ready  input  1  downstream accepts o_word this cycle.
REQ-014 SHALL have port o_word  output  8  transmitted byte.
REQ-015 SHALL have port o_valid  output  1  o_word is valid.
REQ-016 SHALL have ports o_sof / o_eof  output  1 each  asserted with o_valid on the first / last byte of a frame.
REQ-017 SHALL have port o_size_err  output  1  one-cycle pulse when a request is accepted with i_payload_size > MAX_PAYLOAD_BYTES.
REQ-018 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement the states IDLE, HEAD, PAYLOAD, PAD and GAP; o_ready SHALL be 1 only in IDLE.
REQ-020 On acceptance, the block SHALL register head, payload and size; the size SHALL be clamped to MAX_PAYLOAD_BYTES with an o_size_err pulse on the following cycle.
REQ-021 The first header byte SHALL appear on o_word with o_valid=1 and o_sof=1 exactly one cycle after the acceptance edge.
REQ-022 A byte SHALL advance only on edges where o_valid=1 and i_tx_ready=1; otherwise o_word, o_valid, o_sof and o_eof SHALL hold unchanged.
REQ-023 HEAD -> PAYLOAD after HEAD_BYTES transfers. With size 0, HEAD SHALL go directly to PAD if padding is needed, else to GAP.
REQ-024 PAYLOAD -> PAD after size transfers if HEAD_BYTES+size < MIN_FRAME_BYTES, else -> GAP.
REQ-025 PAD SHALL emit 0x00 bytes until the total count reaches MIN_FRAME_BYTES.
REQ-026 o_eof SHALL mark the last transferred byte of the frame, whether it comes from the header, payload or pad.
REQ-027 GAP SHALL hold o_valid=0 for IFG_CYCLES cycles, then enter IDLE; if IFG_CYCLES=0, the block SHALL go from the last byte directly to IDLE.
REQ-028 i_valid SHALL be ignored outside IDLE; changing the inputs after acceptance SHALL NOT affect the frame in flight.
REQ-029 Byte counters SHALL be sized to hold HEAD_BYTES+MAX(MAX_PAYLOAD_BYTES, MIN_FRAME_BYTES) without wrap-around.
REQ-030 When o_valid=0, o_word SHALL be 0x00.

Reset
REQ-031 Asserting i_reset_n=0 at any time, including mid-frame, SHALL immediately force IDLE and set o_word=0, o_valid=0, o_sof=0, o_eof=0, o_size_err=0, o_busy=0 and o_ready=0.
REQ-032 o_ready SHALL go to 1 on the first edge after reset release; the frame that was interrupted by reset SHALL NOT be resumed.

Structure
REQ-033 The state enumeration and the default frame constants (42, 60, 12) SHALL be placed in shared package ethernet_tx_pkg.
REQ-034 The IFG counter SHALL be the sub-module ethernet_ifg_counter (parameter IFG_CYCLES; ports load and done); all other logic SHALL be in the top module.

Verification
REQ-035 Scenario 1: head bytes 0x01..0x2A, size=18 (payload 0xB0..0xC1), i_tx_ready=1 -> 60 bytes in order, o_sof on byte 0x01, o_eof on 0xC1, no padding, then 12 idle cycles, then o_ready=1.
REQ-036 Scenario 2: size=4 -> 42 header bytes, 4 payload bytes, then 14 bytes of 0x00, with o_eof on the 60th byte.
REQ-037 Scenario 3: size=0 with MIN_FRAME_BYTES=0 -> 42 bytes with o_eof on byte 42; directly GAP after that.
REQ-038 Scenario 4: size=100 -> o_size_err pulses once and exactly 63 payload bytes are sent.
REQ-039 Scenario 5: i_tx_ready toggles 1,0,0,1 during header byte 5 -> o_word stays at byte 5 for 3 cycles; the sequence is then intact.
REQ-040 Scenario 6: i_reset_n=0 at payload byte 10 -> all outputs become 0 in the same cycle; after release, a new frame starts with o_sof.
